axi2apb_ctrl: RTL and testbench

APB master sequencer sitting between the AXI-side request logic and `axi2apb_mux`. It accepts one command at a time, runs a standard APB setup/access sequence, and drives the mux's select and slave index. It then collects the mux's registered read data and slave error one cycle after completion and returns them as a response. A watchdog aborts accesses whose slave never asserts ready.

---
 rtl/axi2apb_ctrl.sv | 142 ++++++++++++++
 tb/tb_axi2apb_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi2apb_ctrl.sv
// axi2apb_ctrl: APB master sequencer driving axi2apb_mux select/index from a one-at-a-time command.
// Latency: accept -> SETUP -> ACCESS (+1 per wait state) -> CAPTURE -> RESP, rsp_valid 4 cycles after accept.
// Backpressure: single transfer in flight; cmd_ready stays low until the response handshakes on rsp_ready.
module axi2apb_ctrl #(
  parameter int MUX_LSB = 12,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  output logic        penable,
  output logic        ctrl_psel,
  output logic [3:0]  ctrl_addr_mux,
  input  logic        ctrl_pready,
  input  logic [31:0] ctrl_prdata,
  input  logic        ctrl_pslverr
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  // Counter needs at least one bit even when the watchdog is disabled.
  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] C_MAX  = '1;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic          r_cmd_ready;
  logic [CW-1:0] r_wd_cnt;
  logic [31:0]   r_paddr;
  logic          r_pwrite;
  logic [31:0]   r_pwdata;
  logic [3:0]    r_pstrb;
  logic [3:0]    r_addr_mux;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;
  logic          w_accept;
  logic          w_timeout;

  // r_cmd_ready is only ever high in IDLE, so it doubles as the accept qualifier.
  assign w_accept  = r_cmd_ready & cmd_valid;
  assign w_timeout = (TIMEOUT != 0) && !ctrl_pready && (r_wd_cnt == C_LAST);

  // Next-state decode for the APB setup/access sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:   w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (ctrl_pready)    w_state_nxt = S_CAPTURE;
        else if (w_timeout) w_state_nxt = S_RESP;
      end
      S_CAPTURE: w_state_nxt = S_RESP;
      S_RESP:    if (rsp_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register; cmd_ready is registered so it reads 0 throughout reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
    end
  end

  // Watchdog: cleared in SETUP (entry to ACCESS), counts non-ready ACCESS cycles, saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_wd_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !ctrl_pready && (r_wd_cnt != C_MAX)) begin
      r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end

  // Command capture; fields hold from SETUP until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_paddr    <= '0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= '0;
      r_pstrb    <= '0;
      r_addr_mux <= '0;
    end else if (w_accept) begin
      r_paddr    <= cmd_addr;
      r_pwrite   <= cmd_write;
      r_pwdata   <= cmd_wdata;
      r_pstrb    <= cmd_write ? cmd_strb : 4'h0;
      r_addr_mux <= cmd_addr[MUX_LSB+3:MUX_LSB];
    end
  end

  // Response capture: mux data is only valid during CAPTURE; timeout aborts with an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_rsp_rdata <= r_pwrite ? 32'h0 : ctrl_prdata;
      r_rsp_err   <= ctrl_pslverr;
    end else if ((r_state == S_ACCESS) && w_timeout) begin
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b1;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign ctrl_psel     = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign penable       = (r_state == S_ACCESS);
  assign rsp_valid     = (r_state == S_RESP);
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_err       = r_rsp_err;
  assign paddr         = r_paddr;
  assign pwrite        = r_pwrite;
  assign pwdata        = r_pwdata;
  assign pstrb         = r_pstrb;
  assign ctrl_addr_mux = r_addr_mux;

endmodule

// File: tb/tb_axi2apb_ctrl.sv
// tb_axi2apb_ctrl: table-driven and randomized checks of axi2apb_ctrl against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: bench drives rsp_ready holds and slave wait states.
module tb_axi2apb_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        penable;
  logic        ctrl_psel;
  logic [3:0]  ctrl_addr_mux;
  logic        ctrl_pready;
  logic [31:0] ctrl_prdata;
  logic        ctrl_pslverr;

  int checks = 0;
  int errors = 0;

  axi2apb_ctrl #(.MUX_LSB(12), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .penable(penable),
    .ctrl_psel(ctrl_psel), .ctrl_addr_mux(ctrl_addr_mux), .ctrl_pready(ctrl_pready),
    .ctrl_prdata(ctrl_prdata), .ctrl_pslverr(ctrl_pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ws;       // slave wait states before ready
    logic [31:0] rdata;    // slave read data
    logic        se;       // slave error
    int          hold;     // cycles rsp_ready held low
    int          exp_cyc;  // cycle of first rsp_valid (accept = 0)
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_nacc; // ACCESS cycles (penable high)
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: decode error (index >= 8) completes at once with error;
  // TO or more wait states abort; otherwise ws+1 ACCESS cycles, rsp 3 cycles after SETUP+ACCESS.
  task automatic model(input vec_t v, output int cyc, output logic [31:0] rd,
                       output logic err, output int nacc);
    if (v.addr[15:12] >= 4'd8) begin
      nacc = 1; cyc = 4; rd = 32'h0; err = 1'b1;
    end else if (v.ws >= TO) begin
      nacc = TO; cyc = 2 + TO; rd = 32'h0; err = 1'b1;
    end else begin
      nacc = v.ws + 1; cyc = 3 + nacc; rd = v.write ? 32'h0 : v.rdata; err = v.se;
    end
  endtask

  // Runs one command starting at a negedge where cmd_ready is expected high; ends one cycle
  // after the response handshake, again at a negedge.
  task automatic do_txn(input vec_t v);
    int         c, nacc, first_psel, first_pen, rsp_cyc;
    logic       prev_hit, dec, stable_ok, hold_ok;
    logic [3:0] exp_strb;
    dec      = (v.addr[15:12] >= 4'd8);
    exp_strb = v.write ? v.strb : 4'h0;
    chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_write = v.write;
    cmd_wdata = v.wdata; cmd_strb = v.strb; rsp_ready = 1'b0;
    c = 0; nacc = 0; first_psel = -1; first_pen = -1; rsp_cyc = -1;
    prev_hit = 1'b0; stable_ok = 1'b1;
    while (rsp_cyc < 0 && c < 60) begin
      @(negedge clk);
      c++;
      cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
      cmd_write = 1'($urandom); cmd_strb = 4'($urandom);
      if (prev_hit) begin
        ctrl_prdata  = dec ? 32'h0 : v.rdata;
        ctrl_pslverr = dec ? 1'b1 : v.se;
      end else begin
        ctrl_prdata  = 32'h0;
        ctrl_pslverr = 1'b0;
      end
      prev_hit = 1'b0;
      if (rsp_valid) rsp_cyc = c;
      if (ctrl_psel) begin
        if (first_psel < 0) first_psel = c;
        if (paddr !== v.addr || pwrite !== v.write || pwdata !== v.wdata ||
            pstrb !== exp_strb || ctrl_addr_mux !== v.addr[15:12]) stable_ok = 1'b0;
      end
      if (ctrl_psel && penable) begin
        if (first_pen < 0) first_pen = c;
        nacc++;
        ctrl_pready = dec || (nacc > v.ws);
        prev_hit    = ctrl_pready;
      end else begin
        ctrl_pready = dec && ctrl_psel;
      end
    end
    chk("psel_first_cycle", first_psel, 1);
    chk("penable_first_cycle", first_pen, 2);
    chk("access_cycles", nacc, v.exp_nacc);
    chk("rsp_valid_cycle", rsp_cyc, v.exp_cyc);
    chk("rsp_rdata", rsp_rdata, v.exp_rd);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk("apb_fields_stable", {31'd0, stable_ok}, 32'd1);
    chk("psel_low_in_resp", {30'd0, ctrl_psel, penable}, 32'd0);
    hold_ok = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== v.exp_rd || rsp_err !== v.exp_err ||
          cmd_ready !== 1'b0 || ctrl_psel !== 1'b0 || penable !== 1'b0) hold_ok = 1'b0;
    end
    if (v.hold > 0) chk("rsp_hold_stable", {31'd0, hold_ok}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_after_handshake", {30'd0, cmd_ready, rsp_valid}, 32'd2);
  endtask

  initial begin
    vec_t v;
    int   mc, mn;
    logic [31:0] mr;
    logic me;
    logic quiet;

    tbl[0] = '{32'h0000_3010, 1'b0, 32'h0000_0000, 4'hF, 0,   32'hCAFE_0001, 1'b0, 0,  4, 32'hCAFE_0001, 1'b0, 1};
    tbl[1] = '{32'h0000_1008, 1'b1, 32'h1234_5678, 4'h5, 3,   32'hDEAD_BEEF, 1'b0, 0,  7, 32'h0000_0000, 1'b0, 4};
    tbl[2] = '{32'h0000_2000, 1'b0, 32'h0000_0000, 4'h0, 100, 32'h1357_2468, 1'b0, 0,  6, 32'h0000_0000, 1'b1, 4};
    tbl[3] = '{32'h0000_2004, 1'b0, 32'h0000_0000, 4'h0, 3,   32'h55AA_55AA, 1'b0, 0,  7, 32'h55AA_55AA, 1'b0, 4};
    tbl[4] = '{32'h0000_9000, 1'b0, 32'h0000_0000, 4'h3, 0,   32'h7777_7777, 1'b0, 0,  4, 32'h0000_0000, 1'b1, 1};
    tbl[5] = '{32'h0000_5004, 1'b0, 32'h0000_0000, 4'h0, 1,   32'h0BAD_F00D, 1'b0, 10, 5, 32'h0BAD_F00D, 1'b0, 2};
    tbl[6] = '{32'h0000_7000, 1'b0, 32'h0000_0000, 4'h0, 2,   32'h1111_2222, 1'b1, 0,  6, 32'h1111_2222, 1'b1, 3};
    tbl[7] = '{32'h0000_600C, 1'b1, 32'hA5A5_A5A5, 4'hA, 0,   32'h3333_4444, 1'b1, 2,  4, 32'h0000_0000, 1'b1, 1};
    tbl[8] = '{32'h0000_100C, 1'b1, 32'h0F0F_0F0F, 4'hF, 4,   32'h0000_0000, 1'b0, 0,  6, 32'h0000_0000, 1'b1, 4};

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_write = 1'b0; cmd_wdata = 32'h0;
    cmd_strb = 4'h0; rsp_ready = 1'b0; ctrl_pready = 1'b0; ctrl_prdata = 32'h0; ctrl_pslverr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_psel_penable", {30'd0, ctrl_psel, penable}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pstrb_pwrite_idx", {23'd0, pwrite, pstrb, ctrl_addr_mux}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 9; i++) do_txn(tbl[i]);

    // Reset asserted while in ACCESS with the slave stalled.
    chk("midrst_accept_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_addr = 32'h0000_4000; cmd_write = 1'b1; cmd_wdata = 32'hFACE_B00C; cmd_strb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_access", {30'd0, ctrl_psel, penable}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_psel_penable", {30'd0, ctrl_psel, penable}, 32'd0);
    chk("midrst_no_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", {31'd0, cmd_ready}, 32'd1);
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid !== 1'b0 || ctrl_psel !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    chk("midrst_rsp_discarded", {31'd0, quiet}, 32'd1);

    // Randomized commands against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      v.addr  = $urandom;
      v.write = 1'($urandom);
      v.wdata = $urandom;
      v.strb  = 4'($urandom);
      v.ws    = $urandom_range(0, 5);
      v.rdata = $urandom;
      v.se    = 1'($urandom);
      v.hold  = $urandom_range(0, 3);
      model(v, mc, mr, me, mn);
      v.exp_cyc = mc; v.exp_rd = mr; v.exp_err = me; v.exp_nacc = mn;
      do_txn(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
